// File: rtl/pc_adder.sv
// pc_adder: WIDTH-bit carry-lookahead adder for PC+4 and branch-target sums.
// Ports:
//   clk, rst (async active-high)
//   a, b      : operands
//   out       : combinational sum
//   out_q     : registered sum
//   cout/ovf/zero : optional flags, present only when ADDER_FLAGS_EN is defined.
module pc_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
`ifdef ADDER_FLAGS_EN
    ,
    output logic             cout,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NG = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("pc_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] out_d;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead inside each 4-bit group; group carries ripple from
    // one group to the next through c[4*i].
    always_comb begin
        logic [3:0] gg;
        logic [3:0] pp;
        logic       ci;
        c  = '0;
        gg = '0;
        pp = '0;
        ci = 1'b0;
        for (int i = 0; i < NG; i++) begin
            gg = g[4*i +: 4];
            pp = p[4*i +: 4];
            ci = c[4*i];
            c[4*i+1] = gg[0]
                     | (pp[0] & ci);
            c[4*i+2] = gg[1]
                     | (pp[1] & gg[0])
                     | (pp[1] & pp[0] & ci);
            c[4*i+3] = gg[2]
                     | (pp[2] & gg[1])
                     | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & ci);
            c[4*i+4] = gg[3]
                     | (pp[3] & gg[2])
                     | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0])
                     | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
        end
        out_d = p ^ c[WIDTH-1:0];
    end

    assign out = out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef ADDER_FLAGS_EN
    assign cout = c[WIDTH];
    assign ovf  = (a[WIDTH-1] == b[WIDTH-1])
               && (out_d[WIDTH-1] != a[WIDTH-1]);
    assign zero = ~|out_d;
`else
    // Final carry has no consumer without the flag outputs.
    logic unused_cout;
    assign unused_cout = c[WIDTH];
`endif

endmodule

// File: tb/tb_pc_adder.sv
// tb_pc_adder: scoreboard bench for pc_adder.
// Driver pushes reference results; a negedge monitor pops and compares.
module tb_pc_adder;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cy;
        logic         ov;
        logic         zr;
    } item_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
`ifdef ADDER_FLAGS_EN
    logic         cout;
    logic         ovf;
    logic         zero;
`endif

    int    tests;
    int    fails;
    item_t sb[$];
    bit    mon_en;
    logic [W-1:0] exp_q;

    pc_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .out   (out),
        .out_q (out_q)
`ifdef ADDER_FLAGS_EN
        ,
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide integer arithmetic.
    function automatic item_t model(input logic [W-1:0] x,
                                    input logic [W-1:0] y);
        item_t       it;
        longint      s_u;
        longint      s_s;
        s_u    = longint'({1'b0, x}) + longint'({1'b0, y});
        s_s    = longint'($signed(x)) + longint'($signed(y));
        it.a   = x;
        it.b   = y;
        it.sum = W'(s_u % (64'd1 << W));
        it.cy  = (s_u >= (64'sd1 <<< W));
        it.ov  = (s_s > ((64'sd1 <<< (W-1)) - 1))
              || (s_s < -(64'sd1 <<< (W-1)));
        it.zr  = (it.sum == 0);
        return it;
    endfunction

    task automatic drive(input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        sb.push_back(model(x, y));
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d items left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: combinational result for the current vector, and the
    // registered result of the vector before it.
    always @(negedge clk) begin
        if (mon_en && sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            check("out", out, it.sum);
            check("out_q", out_q, exp_q);
`ifdef ADDER_FLAGS_EN
            check("cout", W'(cout), W'(it.cy));
            check("ovf", W'(ovf), W'(it.ov));
            check("zero", W'(zero), W'(it.zr));
`endif
            exp_q = it.sum;
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        mon_en = 1'b0;
        exp_q  = '0;
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        #2;
        check("reset_out_q", out_q, '0);
        check("reset_out", out, '0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        drive(32'd0, 32'd4);
        drive(32'd10, 32'd4);
        drive(32'd14, 32'd4);
        drive(32'hFFFF_FFFC, 32'd4);
        drive(32'h7FFF_FFFF, 32'd1);
        drive(32'h8000_0000, 32'h8000_0000);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(32'hFFFF_FFFF, 32'd1);
        drive(32'h0000_000F, 32'h0000_0001);
        drive(32'd14, 32'd4);
        drain();

        // Async reset between edges: out_q clears at once, out holds.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_out_q", out_q, 32'd18);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_q", out_q, '0);
        check("async_rst_out", out, 32'd18);
        @(negedge clk);
        check("held_rst_out_q", out_q, '0);
        @(posedge clk);
        #1;
        check("rst_edge_out_q", out_q, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_out_q", out_q, 32'd18);
        exp_q  = 32'd18;
        mon_en = 1'b1;

        for (int i = 0; i < 1200; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 7))
                0: y = 32'd4;
                1: y = -x;
                2: x = 32'hFFFF_FFFF;
                default: ;
            endcase
            drive(x, y);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
